uart_rx_byte: RTL and testbench

- UART 8-bit receiver; deserialises the FPGA serial RX pin into bytes.
- Sits directly upstream of the LED display stage.
- rx_byte drives that stage's byte input; rx_valid drives its enable input.
- Emits one single-cycle valid pulse per good frame and flags malformed frames.

---
 rtl/uart_rx_byte.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8-bit UART receiver. The serial line is passed through a
// 2-flop synchroniser. Each frame is sampled at mid-bit and delivered as a byte
// with a one-cycle rx_valid pulse. A frame whose stop bit is low is reported
// with a one-cycle frame_err pulse, and the receiver then waits for the line
// to return high.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, an even-parity
// bit is expected between the data bits and the stop bit. When it is not
// defined, the frame is 8N1 and parity_err is tied low.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  logic [1:0]       rx_sync_q;
  logic             rx_s;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             frame_err_q;
  // These flags record the stop-bit decision. The pulses they produce appear
  // one cycle later.
  logic             valid_pend_q;
  logic             ferr_pend_q;
  logic             perr_now_s;

`ifdef UART_RX_PARITY_EN
  logic             par_bad_q;
  logic             perr_pend_q;
  logic             parity_err_q;

  // A received word fails even parity when the XOR of its data and parity bits is 1.
  function automatic logic even_parity_fail(input logic [7:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction

  assign perr_now_s = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign perr_now_s = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign rx_s      = rx_sync_q[1];
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

  // Bring the asynchronous rx pin into the clk domain. Both flops reset to the idle-high level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_q <= 2'b11;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx};
    end
  end

  // Receiver FSM: bit timing, data shifting, stop/parity checks and the registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      idx_q        <= 3'd0;
      shift_q      <= 8'h00;
      rx_byte_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      valid_pend_q <= 1'b0;
      ferr_pend_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      perr_pend_q  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Each pulse lasts one cycle. It follows the pending flag that was set
      // on the previous cycle.
      rx_valid_q   <= valid_pend_q;
      frame_err_q  <= ferr_pend_q;
      valid_pend_q <= 1'b0;
      ferr_pend_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= perr_pend_q;
      perr_pend_q  <= 1'b0;
`endif
      if (valid_pend_q) begin
        rx_byte_q <= shift_q;
      end else begin
        rx_byte_q <= rx_byte_q;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= CNT_ZERO;
          idx_q <= 3'd0;
          if (!rx_s) begin
            state_q <= ST_START;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= CNT_ZERO;
            idx_q <= 3'd0;
            // If the line is high again at mid start bit, the low level was
            // only a glitch, so the frame is dropped.
            if (!rx_s) begin
              state_q <= ST_DATA;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            shift_q <= {rx_s, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q     <= CNT_ZERO;
            par_bad_q <= even_parity_fail(shift_q, rx_s);
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= CNT_ZERO;
`ifdef UART_RX_PARITY_EN
            perr_pend_q <= perr_now_s;
`endif
            // The receiver returns to IDLE at mid stop bit, so the next start
            // edge can be accepted without any idle gap.
            if (rx_s) begin
              valid_pend_q <= ~perr_now_s;
              state_q      <= ST_IDLE;
            end else begin
              ferr_pend_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_BREAK: begin
          // A line held low reports one framing error and then waits here.
          cnt_q <= CNT_ZERO;
          if (rx_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_BREAK;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= CNT_ZERO;
          idx_q   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte. CLKS_PER_BIT is 16.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx_byte;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Cycles from the rising edge before the rx fall to the cycle in which rx_valid is high.
  localparam int LAT   = 9*CPB + CPB/2 + 4 + PAR_BITS*CPB;
  localparam int FRAME = (10 + PAR_BITS) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int         cyc = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_clash = 0;
  int         last_valid_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  int         n_tests = 0;
  int         n_fail = 0;
  int         frame_start = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count the output pulses and record their timing. Sampling is on the falling edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid        = n_valid + 1;
      last_valid_cyc = cyc;
      last_byte      = rx_byte;
      if (frame_err === 1'b1 || parity_err === 1'b1) n_clash = n_clash + 1;
    end
    if (frame_err === 1'b1)  n_ferr = n_ferr + 1;
    if (parity_err === 1'b1) n_perr = n_perr + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_good);
    frame_start = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    hold(par_good ? (^d) : ~(^d), CPB);
`else
    if (par_good) hold(stop_b, 0);
`endif
    hold(stop_b, CPB);
  endtask

  int         sv, sf, sp, v1, v2, lat;
  logic [7:0] b1, b2;

  initial begin
    // Reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_byte",  {24'h0, rx_byte}, 32'h00);
    check_eq("rst_valid", {31'h0, rx_valid}, 32'h0);
    check_eq("rst_ferr",  {31'h0, frame_err}, 32'h0);
    check_eq("rst_perr",  {31'h0, parity_err}, 32'h0);
    check_eq("rst_busy",  {31'h0, busy}, 32'h0);
    rst = 1'b0;
    hold(1'b1, 5);

    // Start glitch: rx is low for 5 clocks and then high again
    sv = n_valid; sf = n_ferr;
    hold(1'b0, 5);
    hold(1'b1, 10);
    check_eq("glitch_busy",   {31'h0, busy}, 32'h0);
    check_eq("glitch_pulses", n_valid - sv + n_ferr - sf, 32'd0);
    check_eq("glitch_byte",   {24'h0, rx_byte}, 32'h00);

    // Good frame 0xA5
    sv = n_valid; sf = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b1);
    lat = last_valid_cyc - frame_start;
    hold(1'b1, 20);
    check_eq("good_valid_cnt", n_valid - sv, 32'd1);
    check_eq("good_latency_window", {31'h0, (lat >= LAT-1 && lat <= LAT+1)}, 32'd1);
    check_eq("good_byte",     {24'h0, rx_byte}, 32'hA5);
    check_eq("good_ferr_cnt", n_ferr - sf, 32'd0);
    check_eq("good_busy",     {31'h0, busy}, 32'h0);

    // Framing error: 0x3C sent with a low stop bit, then the line held low for 40 more cycles
    sv = n_valid; sf = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b0, 40);
    hold(1'b1, 20);
    check_eq("ferr_cnt",       n_ferr - sf, 32'd1);
    check_eq("ferr_valid_cnt", n_valid - sv, 32'd0);
    check_eq("ferr_byte_kept", {24'h0, rx_byte}, 32'hA5);
    check_eq("ferr_busy",      {31'h0, busy}, 32'h0);
    sv = n_valid;
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_eq("after_ferr_valid", n_valid - sv, 32'd1);
    check_eq("after_ferr_byte",  {24'h0, rx_byte}, 32'h3C);

    // Back-to-back frames 0x00 then 0xFF with no idle gap
    sv = n_valid;
    send_frame(8'h00, 1'b1, 1'b1);
    v1 = last_valid_cyc; b1 = last_byte;
    send_frame(8'hFF, 1'b1, 1'b1);
    hold(1'b1, 20);
    v2 = last_valid_cyc; b2 = last_byte;
    check_eq("b2b_valid_cnt", n_valid - sv, 32'd2);
    check_eq("b2b_spacing",   v2 - v1, FRAME);
    check_eq("b2b_byte1",     {24'h0, b1}, 32'h00);
    check_eq("b2b_byte2",     {24'h0, b2}, 32'hFF);

    // Reset during data bit 3 of 0x55. The sender abandons the frame.
    sv = n_valid; sf = n_ferr;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b0, 8);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check_eq("midrst_byte",  {24'h0, rx_byte}, 32'h00);
    check_eq("midrst_busy",  {31'h0, busy}, 32'h0);
    check_eq("midrst_valid", {31'h0, rx_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 40);
    check_eq("midrst_no_pulse", n_valid - sv + n_ferr - sf, 32'd0);
    sv = n_valid;
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_eq("post_rst_valid", n_valid - sv, 32'd1);
    check_eq("post_rst_byte",  {24'h0, rx_byte}, 32'h81);

`ifdef UART_RX_PARITY_EN
    // Parity: 0x07 needs parity bit 1 for even parity
    sv = n_valid; sp = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 20);
    check_eq("par_ok_valid", n_valid - sv, 32'd1);
    check_eq("par_ok_byte",  {24'h0, rx_byte}, 32'h07);
    check_eq("par_ok_perr",  n_perr - sp, 32'd0);
    sv = n_valid; sp = n_perr;
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 20);
    check_eq("par_bad_perr",  n_perr - sp, 32'd1);
    check_eq("par_bad_valid", n_valid - sv, 32'd0);
    check_eq("par_bad_byte",  {24'h0, rx_byte}, 32'h07);
`else
    check_eq("no_parity_pulses", n_perr, 32'd0);
`endif

    check_eq("valid_error_overlap", n_clash, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
